rr_dispatch: RTL and testbench
==============================

// Module: rr_dispatch
// PURPOSE
//  One-to-many round-robin dispatcher: the distribution-side counterpart of the W:1 arbiters.
//  Accepts one valid/ready input stream and issues each beat to exactly one of W consumers.
//  A consumer is eligible only while it holds credits; each beat costs 1 credit, each i_credit pulse returns 1.
//  Sits in front of W identical downstream engines/queues; outputs registered, no downstream backpressure.
// PARAMETERS
//  W        4   number of consumers (>=2)
//  DATA_W   32  payload width
//  CREDITS  2   initial/maximum credits per consumer (>=1); CNT_W = $clog2(CREDITS+1)
// PORTS
//  clk        in   1       clock
//  rst        in   1       synchronous reset, active-high
//  i_vld      in   1       input beat valid
//  i_data     in   DATA_W  input payload
//  o_rdy      out  1       dispatcher can accept a beat this cycle
//  o_vld      out  W       one-hot per-consumer beat valid (registered)
//  o_data     out  DATA_W  payload bus shared by all consumers (registered)
//  i_credit   in   W       per-consumer credit-return pulse, 1 credit per cycle per bit
//  o_ovf      out  1       sticky: credit returned to a consumer already at CREDITS
// BEHAVIOUR
//  - Reset (rst=1 at a clk edge): ptr=0, all cnt[k]=CREDITS, o_vld='0, o_data='0, o_ovf=0.
//    Mid-operation reset discards any beat in flight; a credit pulse in the reset cycle is ignored.
//  - elig[k] = (cnt[k] != 0). o_rdy = |elig; purely from state, never depends on i_vld.
//  - accept = i_vld & o_rdy.
//  - sel = first k in ptr, ptr+1, .., W-1, 0, .., ptr-1 with elig[k] (wrap-around search).
//  - On accept, at the next clk edge: o_vld = onehot(sel), o_data = i_data, ptr = (sel+1) mod W.
//    Latency 1 cycle; o_vld is high exactly one cycle per beat.
//  - Without accept: o_vld='0 next cycle; o_data holds its last value; ptr unchanged.
//  - Counter update per k, evaluated each cycle:
//    - dec = accept & (sel==k), inc = i_credit[k]
//    - dec & inc: cnt unchanged
//    - dec only: cnt-1 (never underflows, since eligibility requires cnt>0)
//    - inc only: cnt+1, or, if cnt==CREDITS, cnt held and o_ovf set
//  - A returned credit takes effect next cycle: a consumer with cnt==0 and a pulse at cycle N is eligible at N+1.
//  - o_ovf stays set until rst.
//  - Back-to-back accepts permitted every cycle while any credit remains.
//    Full throughput needs W*CREDITS >= round-trip credit latency.
//  - ptr is PTR_W = $clog2(W) bits; if W is not a power of two, ptr wraps W-1 -> 0, never >= W.
// STRUCTURE
//  - Shared package rr_pkg: none required beyond the width helper.
//    Define CNT_W locally as a localparam.
//  - Sub-module rr_credit_ctr (one per consumer, generate loop):
//    - inputs: dec, inc, clk, rst
//    - outputs: cnt nonzero, overflow pulse
//    - parameter CREDITS
//  - Top level contains:
//    - the rotate/priority select: rotate elig right by ptr, find-first-set, un-rotate, encode
//    - the ptr register
//    - the output registers
//    - the o_ovf OR-reduction flop
// TESTING  (W=4, DATA_W=8, CREDITS=2 unless noted)
//  1 Reset:
//    - assert rst 2 cycles, then release
//    - expect o_vld=0000, o_data=00, o_rdy=1, o_ovf=0, all cnt=2
//  2 Rotation:
//    - i_vld=1 for 4 cycles with A0,A1,A2,A3, no credit returns
//    - expect o_vld=0001,0010,0100,1000 on cycles +1..+4 with matching o_data; ptr back to 0
//  3 Exhaustion:
//    - 8 back-to-back beats with no returns; o_rdy=0 on the 9th cycle and the beat is held
//    - pulse i_credit=0100
//    - expect the next cycle o_rdy=1 and the held beat dispatched with o_vld=0100
//  4 Skip:
//    - precondition: only cnt[3]!=0, ptr=1; send beat 5C
//    - expect o_vld=1000, o_data=5C, ptr=0 afterwards
//  5 Simultaneous:
//    - precondition: cnt[0]=1, ptr=0
//    - i_vld=1 together with i_credit=0001
//    - expect dispatch to 0, cnt[0] stays 1
//  6 Overflow/reset:
//    - pulse i_credit=0001 right after reset
//    - expect o_ovf=1 next cycle and cnt[0]=2; o_ovf still 1 after 10 idle cycles
//    - assert rst during a stream
//    - expect o_vld=0000 next cycle and o_ovf=0

Source files
------------

// File: rtl/rr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rr_pkg
// Description : Shared helpers for the round-robin dispatcher family.
// Revision    : 1.0 - initial release
// ============================================================================
package rr_pkg;

    // Bits needed to index n distinct values; never less than one bit.
    function automatic int unsigned rr_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_credit_ctr.sv
`default_nettype none
// ============================================================================
// Module      : rr_credit_ctr
// Description : Per-consumer credit counter. Starts full, spends one credit
//               per dispatched beat, regains one per credit-return pulse and
//               flags a return that would exceed the maximum.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_credit_ctr
    import rr_pkg::*;
#(
    parameter int CREDITS = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_dec,
    input  logic i_inc,
    output logic o_nz,
    output logic o_ovf_pulse
);

    localparam int               CNT_W = rr_width(CREDITS + 1);
    localparam logic [CNT_W-1:0] C_MAX = CNT_W'(CREDITS);
    localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_full;

    assign w_full = (r_cnt == C_MAX);

    // Credit balance: a simultaneous spend and return cancel out; a return
    // while already full is dropped (and reported through o_ovf_pulse).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= C_MAX;
        end else if (i_dec && !i_inc) begin
            r_cnt <= r_cnt - C_ONE;
        end else if (i_inc && !i_dec && !w_full) begin
            r_cnt <= r_cnt + C_ONE;
        end
    end

    assign o_nz        = |r_cnt;
    assign o_ovf_pulse = i_inc & ~i_dec & w_full;

endmodule
`default_nettype wire

// File: rtl/rr_dispatch.sv
`default_nettype none
// ============================================================================
// Module      : rr_dispatch
// Description : One-to-many round-robin dispatcher. Each accepted input beat
//               is issued to exactly one of W credit-holding consumers, with
//               rotating priority starting at the consumer after the last
//               one served. Outputs are registered.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_dispatch
    import rr_pkg::*;
#(
    parameter int W       = 4,
    parameter int DATA_W  = 32,
    parameter int CREDITS = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_vld,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_rdy,
    output logic [W-1:0]      o_vld,
    output logic [DATA_W-1:0] o_data,
    input  logic [W-1:0]      i_credit,
    output logic              o_ovf
);

    localparam int               PTR_W  = rr_width(W);
    localparam logic [PTR_W-1:0] C_LAST = PTR_W'(W - 1);
    localparam logic [PTR_W-1:0] C_ZERO = '0;
    localparam logic [PTR_W:0]   C_W_X  = (PTR_W + 1)'(W);
    localparam logic [W-1:0]     C_BIT0 = W'(1);

    logic [PTR_W-1:0]  r_ptr;
    logic [W-1:0]      r_vld;
    logic [DATA_W-1:0] r_data;
    logic              r_ovf;

    logic [W-1:0]      w_elig;
    logic [W-1:0]      w_ovf_pulse;
    logic [W-1:0]      w_dec;
    logic [2*W-1:0]    w_dbl;
    logic [2*W-1:0]    w_shift;
    logic [W-1:0]      w_rot;
    logic [PTR_W-1:0]  w_idx;
    logic              w_found;
    logic [PTR_W:0]    w_sum;
    logic [PTR_W-1:0]  w_sel;
    logic [PTR_W-1:0]  w_ptr_nxt;
    logic              w_accept;

    // ------------------------------------------------------------------
    // Per-consumer credit counters
    // ------------------------------------------------------------------
    generate
        for (genvar k = 0; k < W; k++) begin : g_ctr
            assign w_dec[k] = w_accept & (w_sel == PTR_W'(k));

            rr_credit_ctr #(
                .CREDITS (CREDITS)
            ) u_ctr (
                .clk         (clk),
                .rst         (rst),
                .i_dec       (w_dec[k]),
                .i_inc       (i_credit[k]),
                .o_nz        (w_elig[k]),
                .o_ovf_pulse (w_ovf_pulse[k])
            );
        end
    endgenerate

    // Ready depends on credit state only, so it never combinationally
    // follows i_vld.
    assign o_rdy    = |w_elig;
    assign w_accept = i_vld & o_rdy;

    // Rotate eligibility so that bit 0 corresponds to the current pointer;
    // doubling the vector makes the shift wrap for any W.
    assign w_dbl   = {w_elig, w_elig};
    assign w_shift = w_dbl >> r_ptr;
    assign w_rot   = w_shift[W-1:0];

    // Find the first eligible consumer in rotated order.
    always_comb begin
        w_found = 1'b0;
        w_idx   = C_ZERO;
        for (int i = 0; i < W; i++) begin
            if (w_rot[i] && !w_found) begin
                w_found = 1'b1;
                w_idx   = PTR_W'(i);
            end
        end
    end

    // Undo the rotation with an explicit mod-W wrap so non-power-of-two
    // consumer counts stay in range.
    always_comb begin
        w_sum = {1'b0, r_ptr} + {1'b0, w_idx};
        if (w_sum >= C_W_X) begin
            w_sum = w_sum - C_W_X;
        end
        w_sel     = w_sum[PTR_W-1:0];
        w_ptr_nxt = (w_sel == C_LAST) ? C_ZERO : (w_sel + PTR_W'(1));
    end

    // Pointer advances past the consumer just served.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= C_ZERO;
        end else if (w_accept) begin
            r_ptr <= w_ptr_nxt;
        end
    end

    // Registered beat outputs: valid is a one-cycle pulse, data holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld  <= '0;
            r_data <= '0;
        end else if (w_accept) begin
            r_vld  <= C_BIT0 << w_sel;
            r_data <= i_data;
        end else begin
            r_vld  <= '0;
        end
    end

    // Sticky overflow: any consumer receiving a credit it cannot hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (|w_ovf_pulse) begin
            r_ovf <= 1'b1;
        end
    end

    assign o_vld  = r_vld;
    assign o_data = r_data;
    assign o_ovf  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_rr_dispatch.sv
`default_nettype none
// ============================================================================
// Module      : tb_rr_dispatch
// Description : Self-checking bench for rr_dispatch (W=4, DATA_W=8,
//               CREDITS=2) with a credit/round-robin reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_dispatch;

    localparam int W       = 4;
    localparam int DATA_W  = 8;
    localparam int CREDITS = 2;

    logic              clk;
    logic              rst;
    logic              i_vld;
    logic [DATA_W-1:0] i_data;
    logic              o_rdy;
    logic [W-1:0]      o_vld;
    logic [DATA_W-1:0] o_data;
    logic [W-1:0]      i_credit;
    logic              o_ovf;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    int                m_cnt [W];
    int                m_ptr;
    logic [W-1:0]      m_vld;
    logic [DATA_W-1:0] m_data;
    logic              m_ovf;
    logic              m_rdy;

    rr_dispatch #(
        .W       (W),
        .DATA_W  (DATA_W),
        .CREDITS (CREDITS)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .i_vld    (i_vld),
        .i_data   (i_data),
        .o_rdy    (o_rdy),
        .o_vld    (o_vld),
        .o_data   (o_data),
        .i_credit (i_credit),
        .o_ovf    (o_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance the reference model by one clock using the specified rules.
    task automatic model_step(input logic v, input logic [DATA_W-1:0] d,
                              input logic [W-1:0] c, input logic r);
        int  sel;
        bit  any;
        any = 0;
        for (int k = 0; k < W; k++) if (m_cnt[k] > 0) any = 1;
        if (r) begin
            for (int k = 0; k < W; k++) m_cnt[k] = CREDITS;
            m_ptr  = 0;
            m_vld  = '0;
            m_data = '0;
            m_ovf  = 1'b0;
        end else begin
            sel = -1;
            if (v && any) begin
                for (int i = 0; i < W; i++)
                    if (sel < 0 && m_cnt[(m_ptr + i) % W] > 0) sel = (m_ptr + i) % W;
            end
            for (int k = 0; k < W; k++) begin
                if (k == sel && !c[k]) m_cnt[k] = m_cnt[k] - 1;
                else if (k != sel && c[k]) begin
                    if (m_cnt[k] == CREDITS) m_ovf = 1'b1;
                    else m_cnt[k] = m_cnt[k] + 1;
                end
            end
            if (sel >= 0) begin
                m_vld  = W'(1) << sel;
                m_data = d;
                m_ptr  = (sel + 1) % W;
            end else begin
                m_vld = '0;
            end
        end
        m_rdy = 1'b0;
        for (int k = 0; k < W; k++) if (m_cnt[k] > 0) m_rdy = 1'b1;
    endtask

    // Drive one cycle of inputs (changed on the falling edge) and sample
    // point lands 1 time unit after the following rising edge.
    task automatic cycle(input logic v, input logic [DATA_W-1:0] d,
                         input logic [W-1:0] c, input logic r);
        @(negedge clk);
        i_vld    = v;
        i_data   = d;
        i_credit = c;
        rst      = r;
        model_step(v, d, c, r);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        cycle(1'b0, '0, '0, 1'b1);
        cycle(1'b0, '0, '0, 1'b1);
        cycle(1'b0, '0, '0, 1'b0);
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({o_rdy, o_ovf, o_vld, o_data} !== {1'b1, 1'b0, 4'b0000, 8'h00})
            $display("FAIL reset: got rdy=%b ovf=%b vld=%b data=%h, want rdy=1 ovf=0 vld=0000 data=00",
                     o_rdy, o_ovf, o_vld, o_data);
        else n_pass++;
        // All counters at CREDITS: exactly W*CREDITS beats accepted, all in order.
        for (int i = 0; i < W * CREDITS; i++) begin
            cycle(1'b1, DATA_W'(8'h10 + i), '0, 1'b0);
            n_checks++;
            if ({o_rdy, o_ovf, o_vld, o_data} !== {m_rdy, m_ovf, m_vld, m_data})
                $display("FAIL reset_credits beat %0d: got rdy=%b vld=%b data=%h, want rdy=%b vld=%b data=%h",
                         i, o_rdy, o_vld, o_data, m_rdy, m_vld, m_data);
            else n_pass++;
        end
    endtask

    task automatic test_rotation();
        logic [W-1:0] exp_vld;
        do_reset();
        for (int i = 0; i < W; i++) begin
            cycle(1'b1, DATA_W'(8'hA0 + i), '0, 1'b0);
            exp_vld = W'(1) << i;
            n_checks++;
            if (o_vld !== exp_vld || o_data !== DATA_W'(8'hA0 + i) || o_rdy !== 1'b1)
                $display("FAIL rotation beat %0d: got vld=%b data=%h rdy=%b, want vld=%b data=%h rdy=1",
                         i, o_vld, o_data, o_rdy, exp_vld, 8'hA0 + i);
            else n_pass++;
        end
        // Pointer back at 0: next beat goes to consumer 0.
        cycle(1'b1, 8'hA4, '0, 1'b0);
        n_checks++;
        if (o_vld !== 4'b0001 || o_data !== 8'hA4)
            $display("FAIL rotation wrap: got vld=%b data=%h, want vld=0001 data=a4", o_vld, o_data);
        else n_pass++;
    endtask

    task automatic test_exhaustion();
        do_reset();
        for (int i = 0; i < 8; i++) cycle(1'b1, DATA_W'(8'hB0 + i), '0, 1'b0);
        n_checks++;
        if (o_rdy !== 1'b0 || o_vld !== 4'b1000 || o_data !== 8'hB7)
            $display("FAIL exhaust_empty: got rdy=%b vld=%b data=%h, want rdy=0 vld=1000 data=b7",
                     o_rdy, o_vld, o_data);
        else n_pass++;
        cycle(1'b1, 8'h99, '0, 1'b0);
        n_checks++;
        if (o_rdy !== 1'b0 || o_vld !== 4'b0000 || o_data !== 8'hB7)
            $display("FAIL exhaust_hold: got rdy=%b vld=%b data=%h, want rdy=0 vld=0000 data=b7",
                     o_rdy, o_vld, o_data);
        else n_pass++;
        cycle(1'b1, 8'h99, 4'b0100, 1'b0);
        n_checks++;
        if (o_rdy !== 1'b1 || o_vld !== 4'b0000)
            $display("FAIL exhaust_credit: got rdy=%b vld=%b, want rdy=1 vld=0000", o_rdy, o_vld);
        else n_pass++;
        cycle(1'b1, 8'h99, '0, 1'b0);
        n_checks++;
        if (o_vld !== 4'b0100 || o_data !== 8'h99 || o_rdy !== 1'b0)
            $display("FAIL exhaust_dispatch: got vld=%b data=%h rdy=%b, want vld=0100 data=99 rdy=0",
                     o_vld, o_data, o_rdy);
        else n_pass++;
    endtask

    task automatic test_skip();
        do_reset();
        // 0,1,2,3,0,1,2,3 leaves all empty and the pointer at 0.
        for (int i = 0; i < 8; i++) cycle(1'b1, 8'h00, '0, 1'b0);
        cycle(1'b0, 8'h00, 4'b1001, 1'b0);
        cycle(1'b1, 8'h11, '0, 1'b0);        // consumer 0, ptr -> 1
        n_checks++;
        if (o_vld !== 4'b0001 || o_rdy !== 1'b1)
            $display("FAIL skip_setup: got vld=%b rdy=%b, want vld=0001 rdy=1", o_vld, o_rdy);
        else n_pass++;
        cycle(1'b1, 8'h5C, '0, 1'b0);        // only consumer 3 eligible
        n_checks++;
        if (o_vld !== 4'b1000 || o_data !== 8'h5C || o_rdy !== 1'b0)
            $display("FAIL skip: got vld=%b data=%h rdy=%b, want vld=1000 data=5c rdy=0",
                     o_vld, o_data, o_rdy);
        else n_pass++;
        cycle(1'b0, 8'h00, 4'b1111, 1'b0);
        cycle(1'b1, 8'h5D, '0, 1'b0);        // pointer wrapped to 0
        n_checks++;
        if (o_vld !== 4'b0001 || o_data !== 8'h5D)
            $display("FAIL skip_ptr: got vld=%b data=%h, want vld=0001 data=5d", o_vld, o_data);
        else n_pass++;
    endtask

    task automatic test_simultaneous();
        do_reset();
        for (int i = 0; i < W; i++) cycle(1'b1, 8'h00, '0, 1'b0);  // all cnt=1, ptr=0
        cycle(1'b1, 8'hC0, 4'b0001, 1'b0);
        n_checks++;
        if (o_vld !== 4'b0001 || o_data !== 8'hC0 || o_ovf !== 1'b0)
            $display("FAIL simul_dispatch: got vld=%b data=%h ovf=%b, want vld=0001 data=c0 ovf=0",
                     o_vld, o_data, o_ovf);
        else n_pass++;
        // cnt[0] stays 1: after 1,2,3 one more beat still reaches 0, then empty.
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, DATA_W'(8'hC1 + i), '0, 1'b0);
            n_checks++;
            if ({o_rdy, o_vld, o_data} !== {m_rdy, m_vld, m_data})
                $display("FAIL simul_follow %0d: got rdy=%b vld=%b data=%h, want rdy=%b vld=%b data=%h",
                         i, o_rdy, o_vld, o_data, m_rdy, m_vld, m_data);
            else n_pass++;
        end
    endtask

    task automatic test_overflow_reset();
        do_reset();
        cycle(1'b0, 8'h00, 4'b0001, 1'b0);
        n_checks++;
        if (o_ovf !== 1'b1) $display("FAIL ovf_set: got ovf=%b, want 1", o_ovf);
        else n_pass++;
        for (int i = 0; i < 10; i++) cycle(1'b0, 8'h00, '0, 1'b0);
        n_checks++;
        if (o_ovf !== 1'b1) $display("FAIL ovf_sticky: got ovf=%b, want 1", o_ovf);
        else n_pass++;
        // cnt[0] held at 2: exactly two beats go to consumer 0 within 8.
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, DATA_W'(i), '0, 1'b0);
            n_checks++;
            if ({o_rdy, o_ovf, o_vld, o_data} !== {m_rdy, m_ovf, m_vld, m_data})
                $display("FAIL ovf_cnt beat %0d: got rdy=%b ovf=%b vld=%b, want rdy=%b ovf=%b vld=%b",
                         i, o_rdy, o_ovf, o_vld, m_rdy, m_ovf, m_vld);
            else n_pass++;
        end
        cycle(1'b0, 8'h00, 4'b1111, 1'b0);
        cycle(1'b1, 8'hE0, '0, 1'b0);
        cycle(1'b1, 8'hE1, 4'b0010, 1'b1);   // reset mid-stream, credit ignored
        n_checks++;
        if (o_vld !== 4'b0000 || o_ovf !== 1'b0 || o_data !== 8'h00 || o_rdy !== 1'b1)
            $display("FAIL mid_reset: got vld=%b ovf=%b data=%h rdy=%b, want vld=0000 ovf=0 data=00 rdy=1",
                     o_vld, o_ovf, o_data, o_rdy);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [W-1:0] c;
        logic         v;
        logic         r;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            v = ($urandom_range(0, 3) != 0);
            for (int k = 0; k < W; k++)
                c[k] = (m_cnt[k] < CREDITS) ? ($urandom_range(0, 2) == 0) : 1'b0;
            if ($urandom_range(0, 199) == 0) c = W'($urandom);
            r = ($urandom_range(0, 149) == 0);
            cycle(v, DATA_W'($urandom), c, r);
            n_checks++;
            if ({o_rdy, o_ovf, o_vld, o_data} !== {m_rdy, m_ovf, m_vld, m_data})
                $display("FAIL random cycle %0d: got rdy=%b ovf=%b vld=%b data=%h, want rdy=%b ovf=%b vld=%b data=%h",
                         n, o_rdy, o_ovf, o_vld, o_data, m_rdy, m_ovf, m_vld, m_data);
            else n_pass++;
        end
    endtask

    initial begin
        rst      = 1'b1;
        i_vld    = 1'b0;
        i_data   = '0;
        i_credit = '0;
        for (int k = 0; k < W; k++) m_cnt[k] = CREDITS;
        m_ptr  = 0;
        m_vld  = '0;
        m_data = '0;
        m_ovf  = 1'b0;
        m_rdy  = 1'b1;

        test_reset();
        test_rotation();
        test_exhaustion();
        test_skip();
        test_simultaneous();
        test_overflow_reset();
        test_random();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
